// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported, fixed-latency memory.
// Round-robin on contention; fetch responses are dropped when a redirect kills them in flight.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDRESS_WIDTH-1:0]  i_addr,
    input  logic                      i_flush,
    output logic                      i_gnt,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDRESS_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    output logic                      d_gnt,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             owner_d, owner_d_nxt;   // 1 = D-side owns the in-flight access
    logic             we_flag, we_flag_nxt;
    logic             kill, kill_nxt;
    logic             last_d, last_d_nxt;     // 1 = D-side received the most recent grant
    logic             win_d;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        owner_d_nxt = owner_d;
        we_flag_nxt = we_flag;
        kill_nxt    = kill;
        last_d_nxt  = last_d;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        i_valid     = 1'b0;
        d_valid     = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        // D wins when alone, or on a tie when I-side was granted last
        win_d       = d_req && (!i_req || !last_d);

        case (state)
            IDLE: begin
                // rst gating keeps grants quiet while reset is held
                if (!rst && (i_req || d_req)) begin
                    state_nxt   = WAIT;
                    cnt_nxt     = CNT_LOAD;
                    owner_d_nxt = win_d;
                    last_d_nxt  = win_d;
                    mem_req     = 1'b1;
                    if (win_d) begin
                        d_gnt       = 1'b1;
                        mem_we      = d_we;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        mem_be      = d_be;
                        we_flag_nxt = d_we;
                        kill_nxt    = 1'b0;
                    end else begin
                        i_gnt       = 1'b1;
                        mem_addr    = i_addr;
                        mem_be      = '1;
                        we_flag_nxt = 1'b0;
                        kill_nxt    = i_flush;
                    end
                end
            end
            WAIT: begin
                if (!owner_d && i_flush) kill_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    if (owner_d) begin
                        d_valid = 1'b1;
                        d_rdata = we_flag ? '0 : mem_rdata;
                    end else if (!kill && !i_flush) begin
                        // a redirect in the response cycle itself also kills the fetch
                        i_valid = 1'b1;
                        i_rdata = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_d <= 1'b0;
            we_flag <= 1'b0;
            kill    <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner_d <= owner_d_nxt;
            we_flag <= we_flag_nxt;
            kill    <= kill_nxt;
            last_d  <= last_d_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant cycle + fixed latency), and a LATENCY=1 instance.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_valid, d_gnt, d_valid, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        i_req1, i_flush1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1, mem_rdata1;
    logic [3:0]  d_be1;
    logic        i_gnt1, i_valid1, d_gnt1, d_valid1, mem_req1, mem_we1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_flush(i_flush1),
        .i_gnt(i_gnt1), .i_valid(i_valid1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_be(d_be1),
        .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_be(mem_be1), .mem_rdata(mem_rdata1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: a granted access occupies cycles grant..grant+LAT
    int  cyc = 0;
    int  m_resp = -1;
    bit  m_own_d, m_we, m_kill, m_last_d;

    logic        e_i_gnt, e_d_gnt, e_i_valid, e_d_valid, e_mem_req, e_mem_we;
    logic [31:0] e_i_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic [3:0]  e_mem_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_resp   = -1;
        m_own_d  = 1'b0;
        m_we     = 1'b0;
        m_kill   = 1'b0;
        m_last_d = 1'b0;
    endtask

    task automatic step(input bit ir, input logic [31:0] ia, input bit fl,
                        input bit dr, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe,
                        input logic [31:0] rd);
        bit busy, wd;
        @(negedge clk);
        i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
        mem_rdata = rd;
        e_i_gnt = 0; e_d_gnt = 0; e_i_valid = 0; e_d_valid = 0; e_mem_req = 0; e_mem_we = 0;
        e_i_rdata = 0; e_d_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_be = 0;
        busy = (cyc <= m_resp);
        if (busy && cyc == m_resp) begin
            if (m_own_d) begin
                e_d_valid = 1;
                e_d_rdata = m_we ? 32'h0 : rd;
            end else if (!(m_kill || fl)) begin
                e_i_valid = 1;
                e_i_rdata = rd;
            end
        end
        if (busy && !m_own_d && fl) m_kill = 1;
        if (!busy && (ir || dr)) begin
            wd = dr && (!ir || !m_last_d);
            e_mem_req = 1;
            if (wd) begin
                e_d_gnt = 1; e_mem_we = dwe; e_mem_addr = da; e_mem_wdata = dwd; e_mem_be = dbe;
                m_we = dwe; m_kill = 0;
            end else begin
                e_i_gnt = 1; e_mem_addr = ia; e_mem_be = 4'hF;
                m_we = 0; m_kill = fl;
            end
            m_own_d  = wd;
            m_last_d = wd;
            m_resp   = cyc + LAT;
        end
        #1;
        chk("i_gnt", i_gnt, e_i_gnt);
        chk("d_gnt", d_gnt, e_d_gnt);
        chk("i_valid", i_valid, e_i_valid);
        chk("d_valid", d_valid, e_d_valid);
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("mem_req", mem_req, e_mem_req);
        chk("mem_we", mem_we, e_mem_we);
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("mem_be", mem_be, e_mem_be);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i_gnt"}, i_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_i_valid"}, i_valid, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_i_gnt1"}, i_gnt1, 0);
        chk({tag, "_mem_req1"}, mem_req1, 0);
    endtask

    // Reset asserted mid-cycle with requests still high; outputs must drop at once
    task automatic reset_now(input bit hold_req);
        @(negedge clk);
        rst = 1; i_req = hold_req; d_req = hold_req; i_req1 = hold_req;
        d_addr = 32'h1234; i_addr = 32'h5678; mem_rdata = 32'hA5A5_A5A5;
        #1 chk_zero("rst_a");
        @(negedge clk);
        #1 chk_zero("rst_b");
        i_req = 0; d_req = 0; i_req1 = 0;
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic        hr, hd, hwe;
        logic [31:0] ha, hda, hwd, rd;
        logic [3:0]  hbe;
        bit          fl;

        rst = 1;
        i_req = 0; i_addr = 0; i_flush = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        i_req1 = 0; i_addr1 = 0; i_flush1 = 0; d_req1 = 0; d_we1 = 0;
        d_addr1 = 0; d_wdata1 = 0; d_be1 = 0; mem_rdata1 = 0;
        model_reset();
        reset_now(0);

        // Single fetch
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("tp_fetch_gnt", i_gnt, 1);
        chk("tp_fetch_addr", mem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1111);
        chk("tp_fetch_v1", i_valid, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093);
        chk("tp_fetch_v2", i_valid, 1);
        chk("tp_fetch_rdata", i_rdata, 32'h0050_0093);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h2222);
        chk("tp_fetch_v3", i_valid, 0);

        // Contention after reset: D, I, D at cycles 0, 3, 6
        reset_now(0);
        for (int k = 0; k < 9; k++) begin
            step(1, 32'h200, 0, 1, 0, 32'h300, 0, 4'hF, 32'hC000_0000 + k);
            chk("tp_cont_dgnt", d_gnt, (k == 0 || k == 6));
            chk("tp_cont_ignt", i_gnt, (k == 3));
        end
        idle(3);

        // Store
        step(0, 0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        chk("tp_st_we", mem_we, 1);
        chk("tp_st_be", mem_be, 4'b0011);
        chk("tp_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h7777);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8888);
        chk("tp_st_ack", d_valid, 1);
        chk("tp_st_rdata", d_rdata, 0);

        // Flush kills the in-flight fetch; next fetch unaffected
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 32'h2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h3);
        chk("tp_fl_killed", i_valid, 0);
        step(1, 32'h80, 0, 0, 0, 0, 0, 0, 32'h4);
        chk("tp_fl_regnt", i_gnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
        chk("tp_fl_data", i_rdata, 32'hCAFE_F00D);

        // Reset in the middle of a D read
        step(0, 0, 0, 1, 0, 32'h500, 0, 4'hF, 32'h0);
        reset_now(1);
        step(0, 0, 0, 1, 0, 32'h504, 0, 4'hF, 32'h9);
        chk("tp_rst_regnt", d_gnt, 1);
        idle(3);

        // Randomized traffic against the model
        hr = 0; hd = 0; ha = 0; hda = 0; hwd = 0; hwe = 0; hbe = 0;
        for (int k = 0; k < 400; k++) begin
            if (!hr && $urandom_range(0, 2) == 0) begin hr = 1; ha = $urandom; end
            if (!hd && $urandom_range(0, 2) == 0) begin
                hd = 1; hda = $urandom; hwd = $urandom; hwe = 1'($urandom); hbe = 4'($urandom);
            end
            fl = ($urandom_range(0, 5) == 0);
            step(hr, ha, fl, hd, hwe, hda, hwd, hbe, $urandom);
            if (e_i_gnt) hr = 0;
            if (e_d_gnt) hd = 0;
        end
        idle(3);

        // LATENCY=1 back-to-back fetches
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_req1 = 1;
            i_addr1 = 32'h40 + 32'(4 * (k / 2));
            rd = $urandom;
            mem_rdata1 = rd;
            #1;
            chk("l1_gnt", i_gnt1, (k % 2 == 0));
            chk("l1_valid", i_valid1, (k % 2 == 1));
            chk("l1_rdata", i_rdata1, (k % 2 == 1) ? rd : 32'h0);
            chk("l1_memreq", mem_req1, (k % 2 == 0));
            chk("l1_addr", mem_addr1, (k % 2 == 0) ? 32'h40 + 32'(4 * (k / 2)) : 32'h0);
            chk("l1_dside", {d_gnt1, d_valid1, mem_we1}, 0);
        end
        @(negedge clk);
        i_req1 = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
